// File: rtl/alu_flag_wb.sv
// alu_flag_wb: ALU writeback stage with a 2-entry result FIFO, Z/N/V flags and overflow bookkeeping.
module alu_flag_wb #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_result,
  input  logic             in_err,
  input  logic [1:0]       in_opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_result,
  output logic             out_err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v,
  output logic [CNT_W-1:0] ovf_cnt,
  output logic             bad_err,
  input  logic             clr_err
);
  localparam int DEPTH = 2;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
  state_t     state, state_nx;
  logic [4:0] mem [DEPTH];
  logic       wr_ptr, rd_ptr, push, pop;
  // ready comes from registered occupancy only, so a full buffer ignores a same-cycle pop
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_result, out_err} = mem[rd_ptr];
  always_comb begin
    state_nx = state;
    state_nx = (push && !pop) ? state_t'(state + 2'd1) :
               (pop && !push) ? state_t'(state - 2'd1) : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY;
      mem     <= '{default: '0};
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      flag_z  <= 1'b0;
      flag_n  <= 1'b0;
      flag_v  <= 1'b0;
      ovf_cnt <= '0;
      bad_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) begin
        mem[wr_ptr] <= {in_result, in_err};
        wr_ptr      <= ~wr_ptr;
        flag_z      <= in_result == 4'b0000;
        if (in_opcode[1]) begin
          flag_n <= in_result[3];
          flag_v <= in_err;
        end
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (clr_err) begin
        ovf_cnt <= '0;
        bad_err <= 1'b0;
      end else begin
        if (push && in_opcode[1] && in_err && ovf_cnt != '1) ovf_cnt <= ovf_cnt + 1'b1;
        if (push && !in_opcode[1] && in_err) bad_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_flag_wb.sv
// tb_alu_flag_wb: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_alu_flag_wb;
  localparam int CW   = 2;
  localparam int MAXC = (1 << CW) - 1;
  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_err = 1'b0, out_ready = 1'b0, clr_err = 1'b0;
  logic [3:0]    in_result = '0;
  logic [1:0]    in_opcode = '0;
  logic          in_ready, out_valid, out_err, flag_z, flag_n, flag_v, bad_err;
  logic [3:0]    out_result;
  logic [CW-1:0] ovf_cnt;
  int            n_cmp = 0, n_bad = 0;
  logic [4:0]    q[$];
  logic          mz, mn, mv, mb;
  int            mc;

  alu_flag_wb #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_err(in_err), .in_opcode(in_opcode),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_err(out_err), .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v),
    .ovf_cnt(ovf_cnt), .bad_err(bad_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0][4:1]);
      chk("out_err", out_err, q[0][0]);
    end
    chk("flag_z", flag_z, mz);
    chk("flag_n", flag_n, mn);
    chk("flag_v", flag_v, mv);
    chk("ovf_cnt", ovf_cnt, mc);
    chk("bad_err", bad_err, mb);
  endtask

  task automatic model_reset();
    q.delete();
    {mz, mn, mv, mb} = '0;
    mc = 0;
  endtask

  // drive one cycle's inputs at the falling edge, advance the model, check after the next rising edge
  task automatic step(input logic v, input logic [3:0] r, input logic e, input logic [1:0] op,
                      input logic ordy, input logic clr);
    bit push, pop;
    in_valid = v; in_result = r; in_err = e; in_opcode = op; out_ready = ordy; clr_err = clr;
    push = v && q.size() < 2;
    pop  = q.size() != 0 && ordy;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back({r, e});
      mz = r == 4'd0;
      if (op[1]) begin
        mn = r[3];
        mv = e;
      end
    end
    if (clr) begin
      mc = 0;
      mb = 1'b0;
    end else begin
      if (push && op[1] && e && mc < MAXC) mc++;
      if (push && !op[1] && e) mb = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_out_result", out_result, 4'd0);
    chk("rst_out_err", out_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic       v, e, o, c;
    logic [3:0] r;
    logic [1:0] op;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();
    step(1, 4'b1000, 1, 2'b10, 1, 0);
    chk("add_ovf_cnt", ovf_cnt, 1);
    step(1, 4'b0000, 0, 2'b00, 1, 0);
    step(1, 4'b0011, 0, 2'b01, 1, 0);
    step(0, 4'b0000, 0, 2'b00, 1, 0);
    step(0, 4'b0000, 0, 2'b00, 1, 0);
    step(1, 4'b0001, 0, 2'b10, 0, 0);
    step(1, 4'b0010, 0, 2'b10, 0, 0);
    chk("bp_full", in_ready, 1'b0);
    step(1, 4'b0011, 0, 2'b10, 0, 0);
    step(1, 4'b0011, 0, 2'b10, 1, 0);
    step(1, 4'b0011, 0, 2'b10, 1, 0);
    step(0, 4'b0000, 0, 2'b00, 1, 0);
    step(0, 4'b0000, 0, 2'b00, 1, 0);
    step(0, 4'b0000, 0, 2'b00, 1, 1);
    repeat (5) step(1, 4'b1000, 1, 2'b10, 1, 0);
    chk("sat_cnt", ovf_cnt, MAXC);
    step(1, 4'b1000, 1, 2'b11, 1, 1);
    chk("clr_cnt", ovf_cnt, 0);
    step(1, 4'b0101, 1, 2'b01, 1, 0);
    chk("bad_set", bad_err, 1'b1);
    for (int i = 0; i < 10; i++) step(1, 4'(i), 0, 2'(i), 1, 0);
    chk("bad_hold", bad_err, 1'b1);
    step(0, 4'b0000, 0, 2'b00, 1, 1);
    chk("bad_clr", bad_err, 1'b0);
    step(1, 4'b1001, 1, 2'b11, 0, 0);
    step(1, 4'b0110, 0, 2'b10, 0, 0);
    do_reset();
    step(1, 4'b0111, 0, 2'b10, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (in_valid && q.size() == 2) begin
        v = in_valid; r = in_result; e = in_err; op = in_opcode;
      end else begin
        v = $urandom_range(0, 3) != 0; r = 4'($urandom); e = 1'($urandom); op = 2'($urandom);
      end
      o = $urandom_range(0, 2) != 0;
      c = $urandom_range(0, 24) == 0;
      if (i % 700 == 350) do_reset();
      else step(v, r, e, op, o, c);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
